// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS IF stage: datapath width, NOP encoding and fetch FSM states.
package fetch_stage_pkg;

    localparam int unsigned MIPS_DATA_W  = 32;
    localparam int unsigned FETCH_ST_W   = 2;
    localparam logic [31:0] MIPS_NOP     = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [FETCH_ST_W-1:0] {
        StReq  = 2'b00,
        StWait = 2'b01,
        StHold = 2'b10,
        StDrop = 2'b11
    } fetch_state_e;

    // Word-align an address by clearing its byte-offset bits.
    function automatic logic [MIPS_DATA_W-1:0] word_align(input logic [MIPS_DATA_W-1:0] addr);
        return {addr[MIPS_DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold (stall) and flush controls.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       DATA_W    = MIPS_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              stall,
    input  logic [DATA_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_instr,
    output logic              valid,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] instr
);

    logic              valid_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_plus4_q;
    logic [DATA_W-1:0] instr_q;

    // Flush beats load beats hold; an invalid slot always presents NOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP_INSTR;
        end else if (flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load) begin
            valid_q    <= 1'b1;
            pc_q       <= load_pc;
            pc_plus4_q <= load_pc + DATA_W'(4);
            instr_q    <= load_instr;
        end else if (!stall) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    assign valid    = valid_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;
    assign instr    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: one outstanding instruction fetch, next-PC generation, IF/ID loading with
// stall buffering, redirect flush and discard of stale responses.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       DATA_W    = MIPS_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_next,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_target,
    input  logic              stall_id,
    fetch_stage_if.master     imem,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_pc_plus4,
    output logic [DATA_W-1:0] if_id_instr
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] req_pc_q, req_pc_d;
    logic [DATA_W-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_W-1:0] hold_instr_q, hold_instr_d;

    logic              req_valid;
    logic              ifid_load;
    logic              ifid_flush;
    logic [DATA_W-1:0] ld_pc;
    logic [DATA_W-1:0] ld_instr;
    logic [DATA_W-1:0] target_aligned;
    logic              rsp;

    assign rsp            = imem.imem_rsp_valid;
    assign target_aligned = {redirect_target[DATA_W-1:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        pc_next      = pc;
        req_valid    = 1'b0;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ld_pc        = req_pc_q;
        ld_instr     = imem.imem_rsp_data;

        if (!rst) begin
            pc_next = '0;
        end else if (redirect_valid) begin
            // Any response landing this cycle belongs to the wrong path and is dropped.
            pc_next      = target_aligned;
            ifid_flush   = 1'b1;
            hold_pc_d    = '0;
            hold_instr_d = NOP_INSTR;
            case (state_q)
                StWait:  state_d = rsp ? StReq : StDrop;
                StHold:  state_d = StReq;
                StDrop:  state_d = rsp ? StReq : StDrop;
                default: state_d = StReq;
            endcase
        end else begin
            case (state_q)
                StReq: begin
                    req_valid = 1'b1;
                    if (imem.imem_req_ready) begin
                        pc_next  = pc + DATA_W'(4);
                        req_pc_d = pc;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (rsp) begin
                        if (!stall_id || !if_id_valid) begin
                            ifid_load = 1'b1;
                            state_d   = StReq;
                        end else begin
                            hold_pc_d    = req_pc_q;
                            hold_instr_d = imem.imem_rsp_data;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!stall_id) begin
                        ifid_load    = 1'b1;
                        ld_pc        = hold_pc_q;
                        ld_instr     = hold_instr_q;
                        hold_pc_d    = '0;
                        hold_instr_d = NOP_INSTR;
                        state_d      = StReq;
                    end
                end
                StDrop: begin
                    if (rsp) begin
                        state_d = StReq;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StReq;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc;

    fetch_stage_if_id_reg #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .flush      (ifid_flush),
        .stall      (stall_id),
        .load_pc    (ld_pc),
        .load_instr (ld_instr),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .pc_plus4   (if_id_pc_plus4),
        .instr      (if_id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences, and a randomized
// run checked against an in-order instruction-stream model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall_id;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage_if #(.DATA_W(32)) imem_bus ();

    fetch_stage #(
        .DATA_W    (32),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall_id        (stall_id),
        .imem            (imem_bus),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_instr     (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: loads pc_next every cycle.
    always @(posedge clk) pc <= pc_next;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic st, input logic rdr, input logic [31:0] tg);
        @(posedge clk);
        #1;
        rst                     = r;
        imem_bus.imem_req_ready = rdy;
        imem_bus.imem_rsp_valid = rv;
        imem_bus.imem_rsp_data  = rd;
        stall_id                = st;
        redirect_valid          = rdr;
        redirect_target         = tg;
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, rdy, rv, st, rdr;
        logic [31:0] rd, tg;
        logic [31:0] e_pcn;
        logic        e_req, e_v;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] raddr, input logic st, input logic rdr,
                                input logic [31:0] tg, input logic [31:0] e_pcn,
                                input logic e_req, input logic e_v, input logic [31:0] e_pc,
                                input logic [31:0] e_instr);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.st = st; v.rdr = rdr; v.tg = tg;
        v.rd = rv ? memw(raddr) : 32'h0;
        v.e_pcn = e_pcn; v.e_req = e_req; v.e_v = e_v; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] e;
        logic [31:0] exp_pc;
        logic [31:0] paddr;
        logic        pend;
        int          lat;
        int          consumed;

        rst = 1'b0; stall_id = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;

        //            rst rdy rv addr   st rdr tg     | pc_next req v  if_pc  instr
        vecs[0]  = mk(0, 0, 0, 0,      0, 0, 0,       32'h0,   0, 0, 32'h0,  MIPS_NOP);
        vecs[1]  = mk(0, 0, 0, 0,      0, 0, 0,       32'h0,   0, 0, 32'h0,  MIPS_NOP);
        vecs[2]  = mk(1, 1, 0, 0,      0, 0, 0,       32'h4,   1, 0, 32'h0,  MIPS_NOP);
        vecs[3]  = mk(1, 0, 1, 32'h0,  0, 0, 0,       32'h4,   0, 0, 32'h0,  MIPS_NOP);
        vecs[4]  = mk(1, 1, 0, 0,      0, 0, 0,       32'h8,   1, 1, 32'h0,  memw(32'h0));
        vecs[5]  = mk(1, 0, 1, 32'h4,  0, 0, 0,       32'h8,   0, 0, 32'h0,  MIPS_NOP);
        vecs[6]  = mk(1, 1, 0, 0,      0, 0, 0,       32'hC,   1, 1, 32'h4,  memw(32'h4));
        vecs[7]  = mk(1, 0, 1, 32'h8,  0, 0, 0,       32'hC,   0, 0, 32'h4,  MIPS_NOP);
        vecs[8]  = mk(1, 0, 0, 0,      0, 0, 0,       32'hC,   1, 1, 32'h8,  memw(32'h8));
        vecs[9]  = mk(1, 0, 0, 0,      0, 0, 0,       32'hC,   1, 0, 32'h8,  MIPS_NOP);
        vecs[10] = mk(1, 0, 0, 0,      0, 0, 0,       32'hC,   1, 0, 32'h8,  MIPS_NOP);
        vecs[11] = mk(1, 1, 0, 0,      0, 0, 0,       32'h10,  1, 0, 32'h8,  MIPS_NOP);
        vecs[12] = mk(1, 0, 1, 32'hC,  1, 0, 0,       32'h10,  0, 0, 32'h8,  MIPS_NOP);
        vecs[13] = mk(1, 1, 0, 0,      1, 0, 0,       32'h14,  1, 1, 32'hC,  memw(32'hC));
        vecs[14] = mk(1, 0, 1, 32'h10, 1, 0, 0,       32'h14,  0, 1, 32'hC,  memw(32'hC));
        vecs[15] = mk(1, 1, 0, 0,      1, 0, 0,       32'h14,  0, 1, 32'hC,  memw(32'hC));
        vecs[16] = mk(1, 1, 0, 0,      0, 0, 0,       32'h14,  0, 1, 32'hC,  memw(32'hC));
        vecs[17] = mk(1, 1, 0, 0,      0, 0, 0,       32'h18,  1, 1, 32'h10, memw(32'h10));
        vecs[18] = mk(1, 0, 0, 0,      0, 1, 32'h100, 32'h100, 0, 0, 32'h10, MIPS_NOP);
        vecs[19] = mk(1, 1, 1, 32'h14, 0, 0, 0,       32'h100, 0, 0, 32'h10, MIPS_NOP);
        vecs[20] = mk(1, 1, 0, 0,      0, 0, 0,       32'h104, 1, 0, 32'h10, MIPS_NOP);
        vecs[21] = mk(1, 0, 1, 32'h100,0, 0, 0,       32'h104, 0, 0, 32'h10, MIPS_NOP);
        vecs[22] = mk(1, 0, 0, 0,      0, 0, 0,       32'h104, 1, 1, 32'h100,memw(32'h100));

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].st, vecs[i].rdr,
                  vecs[i].tg);
            chk($sformatf("vec%0d_pc_next", i), pc_next, vecs[i].e_pcn);
            chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_bus.imem_req_valid},
                {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d_if_id_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_v});
            chk($sformatf("vec%0d_if_id_pc", i), if_id_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_if_id_instr", i), if_id_instr, vecs[i].e_instr);
        end

        // Redirect while stalled with the hold buffer full; misaligned target.
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("a_pc_next", pc_next, 32'h108);
        drive(1, 0, 1, memw(32'h104), 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        chk("a_if_id_pc", if_id_pc, 32'h104);
        drive(1, 0, 1, memw(32'h108), 1, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 32'h203);
        chk("a_redir_pc_next", pc_next, 32'h200);
        chk("a_redir_req", {31'b0, imem_bus.imem_req_valid}, 32'h0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("a_flush_valid", {31'b0, if_id_valid}, 32'h0);
        chk("a_flush_instr", if_id_instr, MIPS_NOP);
        chk("a_fetch_req", {31'b0, imem_bus.imem_req_valid}, 32'h1);
        chk("a_fetch_addr", imem_bus.imem_addr, 32'h200);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("a_pc_next2", pc_next, 32'h204);
        drive(1, 0, 1, memw(32'h200), 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("a_load_valid", {31'b0, if_id_valid}, 32'h1);
        chk("a_load_pc", if_id_pc, 32'h200);
        chk("a_load_plus4", if_id_pc_plus4, 32'h204);
        chk("a_load_instr", if_id_instr, memw(32'h200));

        // PC wrap, then reset while waiting; the late response must be ignored.
        drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("b_redir_pc_next", pc_next, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("b_wrap_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        chk("b_wrap_pc_next", pc_next, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("b_rst_pc_next", pc_next, 32'h0);
        chk("b_rst_req", {31'b0, imem_bus.imem_req_valid}, 32'h0);
        drive(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("b_post_rst_valid", {31'b0, if_id_valid}, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("b_late_rsp_valid", {31'b0, if_id_valid}, 32'h0);
        chk("b_late_rsp_instr", if_id_instr, MIPS_NOP);
        chk("b_req_addr", imem_bus.imem_addr, 32'h0);

        // Randomized run: ID must consume exactly the sequential stream from the last
        // reset/redirect target, each word carrying its own memory contents.
        exp_pc = 32'h0; pend = 1'b0; lat = 0; paddr = '0; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst             = ($urandom_range(0, 199) != 0);
            stall_id        = ($urandom_range(0, 3) == 0);
            imem_bus.imem_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 29) == 0);
            redirect_target = $urandom;
            imem_bus.imem_rsp_valid = 1'b0;
            imem_bus.imem_rsp_data  = $urandom;
            if (pend) begin
                if (lat == 0) begin
                    imem_bus.imem_rsp_valid = 1'b1;
                    imem_bus.imem_rsp_data  = memw(paddr);
                    pend = 1'b0;
                end else begin
                    lat--;
                end
            end
            if (!rst) pend = 1'b0;
            @(negedge clk);

            if (!rst) e = 32'h0;
            else if (redirect_valid) e = {redirect_target[31:2], 2'b00};
            else if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) e = pc + 32'd4;
            else e = pc;
            chk("rnd_pc_next", pc_next, e);
            chk("rnd_req_blocked", {31'b0, imem_bus.imem_req_valid &&
                (!rst || redirect_valid || pend || imem_bus.imem_rsp_valid)}, 32'h0);
            if (imem_bus.imem_req_valid) chk("rnd_addr", imem_bus.imem_addr, pc);
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready && rst && !redirect_valid) begin
                pend  = 1'b1;
                paddr = pc;
                lat   = $urandom_range(0, 3);
            end
            if (!if_id_valid) chk("rnd_nop", if_id_instr, MIPS_NOP);
            if (rst && !redirect_valid && if_id_valid && !stall_id) begin
                chk("rnd_if_id_pc", if_id_pc, exp_pc);
                chk("rnd_if_id_plus4", if_id_pc_plus4, exp_pc + 32'd4);
                chk("rnd_if_id_instr", if_id_instr, memw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (!rst) exp_pc = 32'h0;
            else if (redirect_valid) exp_pc = {redirect_target[31:2], 2'b00};
        end
        chk("rnd_progress", {31'b0, consumed > 200}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
